// File: rtl/state_history_buffer_if.sv
// Controller-to-history-buffer bus: write port, clear and by-age read port.
// Carries no state of its own; timing is set by the buffer.
// No backpressure: writes and reads are accepted every cycle.
interface state_history_buffer_if #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic             wren;
  logic [WIDTH-1:0] din;
  logic             wr_acc;
  logic [WIDTH-1:0] dout;
  logic             rd_en;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic             rd_err;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             full;

  // Controller side: issues writes, clears and read queries.
  modport master (
    output clr, wren, din, rd_en, rd_idx,
    input  wr_acc, dout, rd_valid, rd_err, rd_data, count, full
  );

  // Buffer side.
  modport slave (
    input  clr, wren, din, rd_en, rd_idx,
    output wr_acc, dout, rd_valid, rd_err, rd_data, count, full
  );
endinterface

// File: rtl/state_history_buffer.sv
// Circular history of the last DEPTH state words; newest word on dout, by-age reads.
// Latency: write visible on dout/count same edge, wr_acc and read results one cycle later.
// No backpressure: one write and one read per cycle, full buffer overwrites the oldest.
module state_history_buffer #(
  parameter int WIDTH       = 35,
  parameter int DEPTH       = 8,   // power of two, at least 2
  parameter bit CHANGE_ONLY = 1'b0
) (
  input logic                  clk,
  input logic                  arst,
  state_history_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic             wr_acc_q;
  logic             rd_valid_q;
  logic             rd_err_q;
  logic [WIDTH-1:0] rd_data_q;

  logic [AW-1:0]    newest_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             is_full;
  logic             dup;
  logic             accept;
  logic             in_range;

  // Pointer arithmetic relies on DEPTH being a power of two so AW-bit math wraps mod DEPTH.
  assign newest_ptr = wp - AW'(1);
  assign rd_ptr     = newest_ptr - bus.rd_idx;
  assign empty      = (cnt == '0);
  assign is_full    = (cnt == (AW+1)'(DEPTH));
  assign in_range   = ({1'b0, bus.rd_idx} < cnt);

  // In change-only mode a write repeating the newest entry is dropped; empty always accepts.
  assign dup    = CHANGE_ONLY && !empty && (bus.din == mem[newest_ptr]);
  assign accept = bus.wren && !bus.clr && !dup;

  // Storage array: no reset, entries beyond count are unreachable.
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= bus.din;
  end

  // Write pointer, saturating occupancy and the write-accepted pulse; clr beats wren.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wp       <= '0;
      cnt      <= '0;
      wr_acc_q <= 1'b0;
    end else if (bus.clr) begin
      wp       <= '0;
      cnt      <= '0;
      wr_acc_q <= 1'b0;
    end else begin
      wr_acc_q <= accept;
      if (accept) begin
        wp <= wp + AW'(1);
        if (!is_full) cnt <= cnt + (AW+1)'(1);
      end
    end
  end

  // Registered by-age read; resolves against pre-edge wp/count, so same-edge writes or clr are not seen.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else if (bus.rd_en) begin
      rd_valid_q <= 1'b1;
      rd_err_q   <= !in_range;
      rd_data_q  <= in_range ? mem[rd_ptr] : '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign bus.dout     = empty ? '0 : mem[newest_ptr];
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.wr_acc   = wr_acc_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_state_history_buffer.sv
// Directed bench for the state history buffer: plain instance and a change-only instance.
// Inputs change 1 time unit after each rising edge, outputs are checked at the same point.
// No backpressure exists, so every step is a single clock.
module tb_state_history_buffer;
  localparam int WIDTH = 35;
  localparam int DEPTH = 8;

  logic clk;
  logic arst;
  int   n_assert;
  int   n_fail;
  int   acc_pulses;

  localparam logic [WIDTH-1:0] VAL_A = 35'h7_ABCD_0123;
  localparam logic [WIDTH-1:0] VAL_B = 35'h1_2345_6789;

  state_history_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) a_if ();
  state_history_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) c_if ();

  state_history_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dut_a (
    .clk (clk),
    .arst(arst),
    .bus (a_if.slave)
  );

  state_history_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) dut_c (
    .clk (clk),
    .arst(arst),
    .bus (c_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.clr = 1'b0; a_if.wren = 1'b0; a_if.din = '0;
    a_if.rd_en = 1'b0; a_if.rd_idx = '0;
  endtask

  task automatic wr_a(input logic [WIDTH-1:0] d);
    a_if.wren = 1'b1; a_if.din = d;
    tick();
    a_if.wren = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_count"},    64'(a_if.count),    64'd0);
    chk({tag, "_full"},     64'(a_if.full),     64'd0);
    chk({tag, "_dout"},     64'(a_if.dout),     64'd0);
    chk({tag, "_wr_acc"},   64'(a_if.wr_acc),   64'd0);
    chk({tag, "_rd_valid"}, 64'(a_if.rd_valid), 64'd0);
    chk({tag, "_rd_err"},   64'(a_if.rd_err),   64'd0);
    chk({tag, "_rd_data"},  64'(a_if.rd_data),  64'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    acc_pulses = 0;
    arst = 1'b1;
    idle_a();
    c_if.clr = 1'b0; c_if.wren = 1'b0; c_if.din = '0;
    c_if.rd_en = 1'b0; c_if.rd_idx = '0;

    // Reset state
    tick();
    check_all_zero("reset");
    tick();
    arst = 1'b0;
    tick();

    // Out-of-range read with two entries
    wr_a(35'd11);
    chk("wr1_acc", 64'(a_if.wr_acc), 64'd1);
    chk("wr1_dout", 64'(a_if.dout), 64'd11);
    chk("wr1_count", 64'(a_if.count), 64'd1);
    wr_a(35'd22);
    chk("wr2_dout", 64'(a_if.dout), 64'd22);
    chk("wr2_count", 64'(a_if.count), 64'd2);
    a_if.rd_en = 1'b1; a_if.rd_idx = 3'd5;
    tick();
    chk("oor_wr_acc", 64'(a_if.wr_acc), 64'd0);
    chk("oor_valid", 64'(a_if.rd_valid), 64'd1);
    chk("oor_err", 64'(a_if.rd_err), 64'd1);
    chk("oor_data", 64'(a_if.rd_data), 64'd0);
    a_if.rd_idx = 3'd1;
    tick();
    chk("idx1_valid", 64'(a_if.rd_valid), 64'd1);
    chk("idx1_err", 64'(a_if.rd_err), 64'd0);
    chk("idx1_data", 64'(a_if.rd_data), 64'd11);
    a_if.rd_en = 1'b0;
    tick();
    chk("rdoff_valid", 64'(a_if.rd_valid), 64'd0);
    chk("rdoff_err", 64'(a_if.rd_err), 64'd0);
    chk("rdoff_hold", 64'(a_if.rd_data), 64'd11);

    // Simultaneous read and write against pre-edge state
    a_if.clr = 1'b1;
    tick();
    a_if.clr = 1'b0;
    chk("clr_count", 64'(a_if.count), 64'd0);
    chk("clr_dout", 64'(a_if.dout), 64'd0);
    wr_a(35'd5);
    wr_a(35'd6);
    wr_a(35'd7);
    chk("rw_pre_count", 64'(a_if.count), 64'd3);
    a_if.wren = 1'b1; a_if.din = 35'd8;
    a_if.rd_en = 1'b1; a_if.rd_idx = 3'd0;
    tick();
    idle_a();
    chk("rw_rd_data", 64'(a_if.rd_data), 64'd7);
    chk("rw_dout", 64'(a_if.dout), 64'd8);
    chk("rw_count", 64'(a_if.count), 64'd4);

    // clr beats a simultaneous write
    a_if.clr = 1'b1; a_if.wren = 1'b1; a_if.din = 35'd9;
    tick();
    idle_a();
    chk("clrwr_count", 64'(a_if.count), 64'd0);
    chk("clrwr_dout", 64'(a_if.dout), 64'd0);
    chk("clrwr_acc", 64'(a_if.wr_acc), 64'd0);
    wr_a(35'd9);
    chk("after_clr_count", 64'(a_if.count), 64'd1);
    chk("after_clr_dout", 64'(a_if.dout), 64'd9);
    chk("after_clr_acc", 64'(a_if.wr_acc), 64'd1);

    // Fill and overflow: 1..10 into an 8-deep buffer
    a_if.clr = 1'b1;
    tick();
    a_if.clr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wr_a(35'(i));
      if (i == 7) chk("fill7_full", 64'(a_if.full), 64'd0);
      if (i == 8) chk("fill8_full", 64'(a_if.full), 64'd1);
    end
    chk("ovf_count", 64'(a_if.count), 64'd8);
    chk("ovf_full", 64'(a_if.full), 64'd1);
    chk("ovf_dout", 64'(a_if.dout), 64'd10);
    a_if.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_if.rd_idx = 3'(i);
      tick();
      chk($sformatf("ovf_rd%0d", i), 64'(a_if.rd_data), 64'(10 - i));
      chk($sformatf("ovf_err%0d", i), 64'(a_if.rd_err), 64'd0);
    end
    // Read on the clr edge sees the pre-clear contents
    a_if.rd_idx = 3'd0; a_if.clr = 1'b1;
    tick();
    a_if.clr = 1'b0;
    chk("rdclr_data", 64'(a_if.rd_data), 64'd10);
    chk("rdclr_err", 64'(a_if.rd_err), 64'd0);
    tick();
    a_if.rd_en = 1'b0;
    chk("postclr_err", 64'(a_if.rd_err), 64'd1);
    chk("postclr_data", 64'(a_if.rd_data), 64'd0);
    chk("postclr_full", 64'(a_if.full), 64'd0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 5; i++) wr_a(35'(100 + i));
    a_if.rd_en = 1'b1; a_if.rd_idx = 3'd0;
    tick();
    a_if.rd_en = 1'b0;
    chk("prerst_count", 64'(a_if.count), 64'd5);
    chk("prerst_valid", 64'(a_if.rd_valid), 64'd1);
    chk("prerst_data", 64'(a_if.rd_data), 64'd104);
    #2;
    arst = 1'b1;
    #1;
    check_all_zero("arst");
    tick();
    arst = 1'b0;
    a_if.rd_en = 1'b1; a_if.rd_idx = 3'd0;
    tick();
    a_if.rd_en = 1'b0;
    chk("postrst_valid", 64'(a_if.rd_valid), 64'd1);
    chk("postrst_err", 64'(a_if.rd_err), 64'd1);
    chk("postrst_data", 64'(a_if.rd_data), 64'd0);

    // Change-only instance: A, A, B, B, A keeps three entries
    c_if.wren = 1'b1;
    c_if.din = VAL_A; tick(); acc_pulses += int'(c_if.wr_acc);
    c_if.din = VAL_A; tick(); acc_pulses += int'(c_if.wr_acc);
    c_if.din = VAL_B; tick(); acc_pulses += int'(c_if.wr_acc);
    c_if.din = VAL_B; tick(); acc_pulses += int'(c_if.wr_acc);
    c_if.din = VAL_A; tick(); acc_pulses += int'(c_if.wr_acc);
    c_if.wren = 1'b0;
    tick(); acc_pulses += int'(c_if.wr_acc);
    chk("co_acc_pulses", 64'(acc_pulses), 64'd3);
    chk("co_count", 64'(c_if.count), 64'd3);
    chk("co_dout", 64'(c_if.dout), 64'(VAL_A));
    c_if.rd_en = 1'b1;
    c_if.rd_idx = 3'd0; tick();
    chk("co_rd0", 64'(c_if.rd_data), 64'(VAL_A));
    c_if.rd_idx = 3'd1; tick();
    chk("co_rd1", 64'(c_if.rd_data), 64'(VAL_B));
    c_if.rd_idx = 3'd2; tick();
    chk("co_rd2", 64'(c_if.rd_data), 64'(VAL_A));
    c_if.rd_idx = 3'd3; tick();
    chk("co_rd3_err", 64'(c_if.rd_err), 64'd1);
    c_if.rd_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/state_history_buffer.md
# state_history_buffer

Parametrised successor to the single-snapshot state register. It keeps the last DEPTH house-state words written by the controller in a circular history, presents the newest word continuously, and answers registered by-age read queries. An optional change-only mode drops writes that repeat the newest entry. It sits between the house controller and the logging/display path.

## Interface
Parameters:
- WIDTH, 35, bits per state word
- DEPTH, 8, number of history entries; power of two, ≥ 2
- CHANGE_ONLY, 0, 1 = suppress writes equal to the newest stored entry
- AW = $clog2(DEPTH) (derived, not overridable)

Ports:
- clk  in  1  clock, posedge
- arst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of history
- wren  in  1  write request
- din  in  WIDTH  state word to store
- wr_acc  out  1  registered pulse: write at previous edge was stored
- dout  out  WIDTH  newest stored entry; 0 when empty
- rd_en  in  1  read request
- rd_idx  in  AW  age of requested entry; 0 = newest
- rd_valid  out  1  registered: read data present this cycle
- rd_err  out  1  registered: requested age ≥ count
- rd_data  out  WIDTH  registered read result
- count  out  AW+1  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH

## Operation
- Storage: DEPTH × WIDTH array, write pointer wp (AW bits), count (AW+1 bits).
- Accepted write: `wren & ~clr & ~(CHANGE_ONLY & count != 0 & din == mem[wp-1])`.
- Effect of an accepted write: mem[wp] ← din, wp ← wp+1 mod DEPTH, count ← min(count+1, DEPTH).
- When full, an accepted write overwrites the oldest entry; count stays DEPTH.
- Change-only: the compare is against the newest entry. An empty buffer always accepts.
- dout = mem[wp-1 mod DEPTH] when count != 0, else 0. It is combinational from registers.
- Read: on an edge with rd_en=1:
  - rd_valid ← 1.
  - If rd_idx < count: rd_data ← mem[wp-1-rd_idx mod DEPTH], rd_err ← 0.
  - Otherwise: rd_data ← 0, rd_err ← 1.
  - With rd_en=0: rd_valid ← 0, rd_err ← 0, and rd_data holds its value.
- Read during write in the same edge: the read resolves against the pre-edge state (old wp and count).
- clr: wp ← 0, count ← 0, wr_acc ← 0. Array contents need not be cleared because they are unreachable.
  - clr wins over a simultaneous wren; that write is dropped.
  - A read on the same edge as clr resolves against the pre-clear state.
- wr_acc ← accepted write, asserted for one cycle per stored word.

## Timing
- Reset (arst high, any time): wp=0, count=0, full=0, dout=0, wr_acc=0, rd_valid=0, rd_err=0, rd_data=0. Array contents are don't-care.
- Reset takes effect immediately and asynchronously, aborting any in-flight read result.
- Write latency: din is visible on dout, count and full after the same posedge (0 added cycles). wr_acc is high during the following cycle.
- Read latency: 1 cycle. rd_data, rd_valid and rd_err are valid in the cycle after the rd_en edge.
- Back-to-back writes and reads are sustained every cycle with no stall.
- count wraps never: it saturates at DEPTH. wp wraps DEPTH-1 → 0.

## Test plan
- Reset: assert arst mid-run with count=5 and rd_valid=1 → all outputs 0 immediately; next read of idx 0 returns rd_err=1, rd_data=0.
- Fill and overflow (DEPTH=8): write 1..10 → count=8, full=1, dout=10. Reads of idx 0..7 return 10,9,…,3. A second read of idx 0 after clr returns rd_err=1.
- Simultaneous read/write: count=3 holding 5,6,7; on one edge write 8 and read idx 0 → rd_data=7 next cycle, dout=8, count=4.
- Change-only (CHANGE_ONLY=1): write A, A, B, B, A → count=3, entries newest-first A,B,A. wr_acc pulses exactly 3 times.
- clr with wren: count=4, assert clr and wren(din=9) together → count=0, dout=0, wr_acc=0. The next write of 9 gives count=1 and dout=9.
- Out-of-range read: count=2, read idx 5 → rd_valid=1, rd_err=1, rd_data=0. Read idx 1 → the older entry with rd_err=0.
